// File: rtl/dmac_slave_regs.sv
// dmac_slave_regs: slave-side register file and descriptor queue of a simple DMA controller.
// Software stages a source, destination and size, pushes them into a 4-deep FIFO and then
// starts a run. The master engine drains the FIFO through the desc_* handshake and reports
// each completed descriptor on op_done.
// Optional feature macro: DMAC_SLAVE_IRQ_EN adds the INTERRUPT / INTERRUPT_ENABLE registers
// and drives irq. Without it, offsets 1 and 2 read 0, writes to them are ignored and irq is 0.
//
// Handshake: desc_valid/desc_ready follow strict valid/ready rules. A descriptor moves on
// every rising edge where both are high. desc_valid does not depend on desc_ready. While
// desc_valid is high, desc_src/desc_dst/desc_size stay stable until the transfer happens.
module dmac_slave_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] to_reg,
    input  logic [31:0] din,
    input  logic        rd_en,
    input  logic [3:0]  rd_addr,
    output logic [31:0] dout,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [31:0] desc_src,
    output logic [31:0] desc_dst,
    output logic [15:0] desc_size,
    input  logic        op_done,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] src_q, dst_q;
    logic [15:0] size_q;
    logic [31:0] fifo_src [4];
    logic [31:0] fifo_dst [4];
    logic [15:0] fifo_size [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic [2:0]  outstanding;
    logic        overflow;
    logic        full, empty, pop, push_req, push_ok, start_req, done_dec;
    logic [31:0] rd_data, int_rd, ie_rd;
    logic        unused_bits;

    assign full      = (count == 3'd4);
    assign empty     = (count == 3'd0);
    assign push_req  = to_reg[6];
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok   = push_req && (!full || pop);
    assign pop       = desc_valid && desc_ready;
    assign start_req = to_reg[0] && din[0];
    assign done_dec  = op_done && (outstanding != 3'd0);

    assign desc_valid = (state == BUSY) && !empty;
    assign desc_src   = fifo_src[rd_ptr];
    assign desc_dst   = fifo_dst[rd_ptr];
    assign desc_size  = fifo_size[rd_ptr];

    // Offset 7 (count) is read-only and offsets 9-15 are reserved, so their strobes go nowhere.
    assign unused_bits = ^{to_reg[15:9], to_reg[7]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state. A run ends only when nothing is queued, nothing is arriving and nothing is in flight.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_req && !empty) state_nxt = BUSY;
            BUSY: if (empty && !push_ok && (outstanding == 3'd0)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Staging registers for the next descriptor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            dst_q  <= '0;
            size_q <= '0;
        end else begin
            if (to_reg[3]) src_q  <= din;
            if (to_reg[4]) dst_q  <= din;
            if (to_reg[5]) size_q <= din[15:0];
        end
    end

    // Descriptor FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_src[i]  <= '0;
                fifo_dst[i]  <= '0;
                fifo_size[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_src[wr_ptr]  <= src_q;
                fifo_dst[wr_ptr]  <= dst_q;
                fifo_size[wr_ptr] <= size_q;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, push_ok} - {2'b0, pop};
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (to_reg[8])       overflow <= 1'b0;
        end
    end

    // Descriptors handed out but not yet reported complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({pop, done_dec})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   outstanding <= outstanding - 3'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef DMAC_SLAVE_IRQ_EN
    logic int_flag, int_en;

    // Interrupt flag is raised by DONE (wins over a same-cycle clear); enable is plain R/W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_flag <= 1'b0;
            int_en   <= 1'b0;
        end else begin
            if (state == DONE)              int_flag <= 1'b1;
            else if (to_reg[1] && din[0])   int_flag <= 1'b0;
            if (to_reg[2])                  int_en   <= din[0];
        end
    end

    assign irq   = int_flag && int_en;
    assign int_rd = {31'b0, int_flag};
    assign ie_rd  = {31'b0, int_en};
`else
    logic unused_irq_bits;
    assign unused_irq_bits = ^to_reg[2:1];
    assign irq    = 1'b0;
    assign int_rd = '0;
    assign ie_rd  = '0;
`endif

    // Read decode. Write-only and reserved offsets read as 0.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            4'd1:    rd_data = int_rd;
            4'd2:    rd_data = ie_rd;
            4'd3:    rd_data = src_q;
            4'd4:    rd_data = dst_q;
            4'd5:    rd_data = {16'b0, size_q};
            4'd7:    rd_data = {29'b0, count};
            4'd8:    rd_data = {28'b0, overflow, empty, full, (state != IDLE)};
            default: rd_data = '0;
        endcase
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      dout <= '0;
        else if (rd_en) dout <= rd_data;
    end

endmodule

// File: tb/tb_dmac_slave_regs.sv
// Bench for dmac_slave_regs. Register reads and descriptor pops are checked against
// queues of expected values filled when the stimulus is driven.
module tb_dmac_slave_regs;

`ifdef DMAC_SLAVE_IRQ_EN
    localparam logic [31:0] IRQ_EN = 32'd1;
`else
    localparam logic [31:0] IRQ_EN = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] to_reg;
    logic [31:0] din;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] dout;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_src, desc_dst;
    logic [15:0] desc_size;
    logic        op_done;
    logic        irq;

    logic [31:0] exp_q[$];
    logic [79:0] desc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    dmac_slave_regs dut (
        .clk(clk), .reset(reset), .to_reg(to_reg), .din(din),
        .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_src(desc_src), .desc_dst(desc_dst), .desc_size(desc_size),
        .op_done(op_done), .irq(irq)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL time_limit: run did not finish, got timeout, want completion");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side of the descriptor handshake: every transfer must match the queue head.
    always @(negedge clk) begin
        if (!reset && desc_valid && desc_ready) begin
            if (desc_q.size() == 0) begin
                check("pop_unexpected", 32'd1, 32'd0);
            end else begin
                logic [79:0] e;
                e = desc_q.pop_front();
                check("pop_src", desc_src, e[79:48]);
                check("pop_dst", desc_dst, e[47:16]);
                check("pop_size", {16'b0, desc_size}, {16'b0, e[15:0]});
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; to_reg = '0; din = '0; rd_en = 1'b0; rd_addr = '0;
        desc_ready = 1'b0; op_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        desc_q.delete();
    endtask

    task automatic write_reg(input int off, input logic [31:0] d);
        @(posedge clk); #1;
        to_reg = 16'h1 << off;
        din    = d;
        @(posedge clk); #1;
        to_reg = '0;
    endtask

    task automatic read_check(input int off, input logic [31:0] e, input string tag);
        @(posedge clk); #1;
        rd_en   = 1'b1;
        rd_addr = 4'(off);
        exp_q.push_back(e);
        @(posedge clk); #1;
        rd_en = 1'b0;
        check(tag, dout, exp_q.pop_front());
    endtask

    task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
        write_reg(3, s);
        write_reg(4, d);
        write_reg(5, z);
        write_reg(6, 32'd0);
        if (desc_q.size() < 4) desc_q.push_back({s, d, z[15:0]});
    endtask

    task automatic pulse_op_done();
        @(posedge clk); #1 op_done = 1'b1;
        @(posedge clk); #1 op_done = 1'b0;
    endtask

    // Watch STATUS until busy drops; irq must rise exactly one sample before that (one DONE cycle).
    task automatic poll_done(input string tag);
        int   drop = -1;
        logic i1 = 1'b0, i2 = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd8;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (dout[0] == 1'b0) begin
                drop = c;
                break;
            end
            i2 = i1;
            i1 = irq;
        end
        rd_en = 1'b0;
        check({tag, "_idle_reached"}, 32'(drop >= 0), 32'd1);
        check({tag, "_irq_at_done"}, {31'b0, i1}, IRQ_EN);
        check({tag, "_irq_before_done"}, {31'b0, i2}, 32'd0);
        check({tag, "_irq_idle"}, {31'b0, irq}, IRQ_EN);
        check({tag, "_valid_idle"}, {31'b0, desc_valid}, 32'd0);
    endtask

    initial begin
        do_reset();

        // Reset state.
        check("rst_dout", dout, 32'd0);
        check("rst_valid", {31'b0, desc_valid}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_src", desc_src, 32'd0);
        read_check(8, 32'h4, "rst_status");
        read_check(7, 32'd0, "rst_count");

        // Start with an empty FIFO is ignored.
        write_reg(0, 32'd1);
        read_check(8, 32'h4, "start_empty_status");
        check("start_empty_valid", {31'b0, desc_valid}, 32'd0);

        // One descriptor; size keeps only its low 16 bits.
        push_desc(32'h100, 32'h200, 32'hABCD_0010);
        read_check(7, 32'd1, "count_one");
        @(posedge clk); #1;
        check("dout_hold", dout, 32'd1);
        read_check(3, 32'h100, "src_rd");
        read_check(4, 32'h200, "dst_rd");
        read_check(5, 32'h10, "size_rd");
        check("head_src", desc_src, 32'h100);
        check("head_size", {16'b0, desc_size}, 32'h10);
        check("idle_valid", {31'b0, desc_valid}, 32'd0);

        // Fill to four and overflow with a fifth.
        for (int i = 1; i <= 4; i++)
            push_desc(32'h1000 + i, 32'h2000 + i, 32'(i));
        read_check(7, 32'd4, "count_full");
        read_check(8, 32'hA, "status_overflow");
        check("head_after_ovf", desc_src, 32'h100);
        write_reg(12, 32'hFFFF_FFFF);
        read_check(12, 32'd0, "reserved12");
        read_check(9, 32'd0, "reserved9");
        read_check(0, 32'd0, "start_reads0");
        read_check(6, 32'd0, "push_reads0");

        // Full FIFO: push and pop in the same cycle.
        write_reg(2, 32'd1);
        write_reg(8, 32'd0);
        read_check(8, 32'h2, "ovf_cleared");
        write_reg(0, 32'h2);
        read_check(8, 32'h2, "start_d0_ignored");
        write_reg(0, 32'd1);
        read_check(8, 32'h3, "busy_full");
        write_reg(3, 32'hA000);
        write_reg(4, 32'hB000);
        write_reg(5, 32'h55);
        @(posedge clk); #1;
        to_reg = 16'h0040; desc_ready = 1'b1;
        desc_q.push_back({32'hA000, 32'hB000, 16'h55});
        @(posedge clk); #1;
        to_reg = '0; desc_ready = 1'b0;
        read_check(7, 32'd4, "pp_count");
        read_check(8, 32'h3, "pp_status");
        desc_ready = 1'b1;
        repeat (5) pulse_op_done();
        poll_done("run1");
        desc_ready = 1'b0;
        check("run1_drained", 32'(desc_q.size()), 32'd0);
        read_check(7, 32'd0, "run1_count");
        read_check(1, IRQ_EN, "run1_int");
        read_check(2, IRQ_EN, "run1_ie");
        write_reg(1, 32'd1);
        check("run1_irq_clr", {31'b0, irq}, 32'd0);
        read_check(1, 32'd0, "run1_int_clr");

        // Two-descriptor run with interrupt enabled.
        do_reset();
        write_reg(2, 32'd1);
        push_desc(32'h300, 32'h400, 32'h20);
        push_desc(32'h500, 32'h600, 32'h30);
        desc_ready = 1'b1;
        write_reg(0, 32'd1);
        repeat (2) pulse_op_done();
        poll_done("run2");
        desc_ready = 1'b0;
        check("run2_drained", 32'(desc_q.size()), 32'd0);
        read_check(8, 32'h4, "run2_status");
        write_reg(1, 32'd1);
        check("run2_irq_clr", {31'b0, irq}, 32'd0);

        // Reset in the middle of a run with one descriptor outstanding.
        do_reset();
        write_reg(2, 32'd1);
        push_desc(32'h700, 32'h800, 32'h40);
        push_desc(32'h900, 32'hA00, 32'h50);
        write_reg(0, 32'd1);
        @(posedge clk); #1 desc_ready = 1'b1;
        @(posedge clk); #1 desc_ready = 1'b0;
        read_check(8, 32'h1, "mid_busy");
        check("mid_valid", {31'b0, desc_valid}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("arst_valid", {31'b0, desc_valid}, 32'd0);
        check("arst_irq", {31'b0, irq}, 32'd0);
        check("arst_dout", dout, 32'd0);
        check("arst_src", desc_src, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        desc_q.delete();
        read_check(7, 32'd0, "arst_count");
        read_check(8, 32'h4, "arst_status");
        pulse_op_done();
        write_reg(2, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("arst_no_irq", {31'b0, irq}, 32'd0);
        read_check(1, 32'd0, "arst_no_int");
        read_check(8, 32'h4, "arst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
